// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multdiv sequencing controller: state encoding,
// default exception status codes and the status destination register.
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  localparam int unsigned TMR_W             = 7;
  localparam logic [4:0]  DEF_STATUS_REG    = 5'd30;
  localparam logic [31:0] DEF_MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DEF_DIV_EXC_CODE  = 32'd5;

endpackage

// File: rtl/multdiv_ctrl_timeout_counter.sv
// WAIT-state watchdog: counts enabled cycles from a synchronous clear and
// flags when the count equals the terminal value. Saturates at the terminal value.
module md_timeout_counter
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == tc_val_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequences one mult/div instruction through the iterative multdiv unit:
// latch operands, pulse start, wait for ready (or time out), then write back.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no operation in flight; a request is latched here
// ST_ISSUE | one-cycle start pulse to the unit, watchdog cleared
// ST_WAIT  | waiting for md_resultRDY or the watchdog terminal count
// ST_DONE  | one-cycle writeback strobe, pipeline released
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [4:0]  STATUS_REG     = DEF_STATUS_REG,
  parameter logic [31:0] MULT_EXC_CODE  = DEF_MULT_EXC_CODE,
  parameter logic [31:0] DIV_EXC_CODE   = DEF_DIV_EXC_CODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_div,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  localparam logic [TMR_W-1:0] TMR_TC = TMR_W'(TIMEOUT_CYCLES - 1);

  md_state_e   state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_div_q, is_div_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_exc_q, wb_exc_d;
  logic        tmr_clr, tmr_en, tmr_tc;
  logic [31:0] exc_code;

  md_timeout_counter #(.W(TMR_W)) u_tmr (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .tc_val_i(TMR_TC),
    .tc_o    (tmr_tc)
  );

  assign exc_code     = is_div_q ? DIV_EXC_CODE : MULT_EXC_CODE;
  assign md_operandA  = a_q;
  assign md_operandB  = b_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_exception = wb_exc_q;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    rd_d         = rd_q;
    is_div_d     = is_div_q;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    wb_exc_d     = wb_exc_q;
    stall        = 1'b0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    wb_valid     = 1'b0;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          a_d      = req_a;
          b_d      = req_b;
          rd_d     = req_rd;
          is_div_d = req_is_div;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Ready is stale here: the unit's iteration counter restarts this cycle.
        stall        = 1'b1;
        md_ctrl_MULT = ~is_div_q;
        md_ctrl_DIV  = is_div_q;
        tmr_clr      = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (md_resultRDY) begin
          wb_data_d = md_exception ? exc_code : md_result;
          wb_rd_d   = md_exception ? STATUS_REG : rd_q;
          wb_exc_d  = md_exception;
          state_d   = ST_DONE;
        end else if (tmr_tc) begin
          wb_data_d = exc_code;
          wb_rd_d   = STATUS_REG;
          wb_exc_d  = 1'b1;
          state_d   = ST_DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: begin
        // req_valid still shows the completed instruction; never reissue it.
        wb_valid = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (reset) begin
      stall        = 1'b0;
      md_ctrl_MULT = 1'b0;
      md_ctrl_DIV  = 1'b0;
      wb_valid     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_exc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      is_div_q  <= is_div_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_exc_q  <= wb_exc_d;
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with a behavioural iterative multdiv unit
// (ready 16 cycles into WAIT for mult, 33 for div; ready stays high until the next start).
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_is_div;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        stall;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  multdiv_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_is_div  (req_is_div),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rd      (req_rd),
    .stall       (stall),
    .md_operandA (md_operandA),
    .md_operandB (md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT),
    .md_ctrl_DIV (md_ctrl_DIV),
    .md_result   (md_result),
    .md_exception(md_exception),
    .md_resultRDY(md_resultRDY),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_exception(wb_exception)
  );

  // Behavioural multdiv unit
  logic [6:0]         m_cnt      = '0;
  logic               m_rdy      = 1'b0;
  logic               m_is_div   = 1'b0;
  logic               m_hold_low = 1'b0;
  logic signed [63:0] m_sa, m_sb, m_prod;

  always @(posedge clock) begin
    if (md_ctrl_MULT || md_ctrl_DIV) begin
      m_cnt    <= '0;
      m_rdy    <= 1'b0;
      m_is_div <= md_ctrl_DIV;
    end else begin
      if (m_cnt != 7'd127) m_cnt <= m_cnt + 7'd1;
      m_rdy <= !m_hold_low && ((int'(m_cnt) + 1) >= (m_is_div ? 33 : 16));
    end
  end

  always_comb begin
    m_sa   = {{32{md_operandA[31]}}, md_operandA};
    m_sb   = {{32{md_operandB[31]}}, md_operandB};
    m_prod = m_sa * m_sb;
    if (m_is_div) begin
      md_result    = (md_operandB == 32'd0) ? 32'd0 : 32'($signed(md_operandA) / $signed(md_operandB));
      md_exception = (md_operandB == 32'd0);
    end else begin
      md_result    = m_prod[31:0];
      md_exception = !((m_prod[63:31] == '0) || (m_prod[63:31] == '1));
    end
  end
  assign md_resultRDY = m_rdy;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one instruction (req_valid left high afterwards, as a pipeline would)
  // and follows it to its writeback, counting cycles from the request cycle.
  task automatic run_op(input string name, input logic is_div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [4:0] exp_rd,
                        input logic [31:0] exp_data, input logic exp_exc, input int exp_lat);
    int  k = 0;
    int  n_mul = 0;
    int  n_div = 0;
    bit  seen = 0;
    bit  stall_ok = 1;
    bit  opnd_ok = 1;
    @(negedge clock);
    check_val({name, " wb_idle"}, wb_valid, 0);
    req_valid = 1'b1; req_is_div = is_div; req_a = a; req_b = b; req_rd = rd;
    #1 check_val({name, " stall_req"}, stall, 1);
    while (!seen && k < 200) begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        req_a = ~a; req_b = a ^ b ^ 32'h5a5a_5a5a; req_rd = ~rd;
      end
      n_mul += int'(md_ctrl_MULT);
      n_div += int'(md_ctrl_DIV);
      if (md_operandA !== a || md_operandB !== b) opnd_ok = 0;
      if (wb_valid) begin
        seen = 1;
        check_val({name, " stall_done"}, stall, 0);
      end else if (!stall) begin
        stall_ok = 0;
      end
    end
    check_val({name, " wb_seen"}, seen, 1);
    check_val({name, " latency"}, k, exp_lat);
    check_val({name, " wb_rd"}, wb_rd, exp_rd);
    check_val({name, " wb_data"}, wb_data, exp_data);
    check_val({name, " wb_exc"}, wb_exception, exp_exc);
    check_val({name, " mult_pulses"}, n_mul, is_div ? 0 : 1);
    check_val({name, " div_pulses"}, n_div, is_div ? 1 : 0);
    check_val({name, " stall_held"}, stall_ok, 1);
    check_val({name, " operands"}, opnd_ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wb;
    int n_pulse;
    reset = 1'b1; req_valid = 1'b0; req_is_div = 1'b0;
    req_a = '0; req_b = '0; req_rd = '0;
    repeat (3) @(negedge clock);
    check_val("rst stall", stall, 0);
    check_val("rst ctrl_mult", md_ctrl_MULT, 0);
    check_val("rst ctrl_div", md_ctrl_DIV, 0);
    check_val("rst wb_valid", wb_valid, 0);
    check_val("rst wb_exc", wb_exception, 0);
    check_val("rst opA", md_operandA, 0);
    check_val("rst opB", md_operandB, 0);
    check_val("rst wb_data", wb_data, 0);
    check_val("rst wb_rd", wb_rd, 0);

    // Request coincident with reset must not be latched
    req_valid = 1'b1; req_a = 32'h1234; req_b = 32'h5678; req_rd = 5'd6;
    #1 check_val("rst_req stall", stall, 0);
    @(negedge clock);
    reset = 1'b0; req_valid = 1'b0;
    n_pulse = 0;
    repeat (4) begin
      @(negedge clock);
      n_pulse += int'(md_ctrl_MULT) + int'(md_ctrl_DIV) + int'(stall);
    end
    check_val("rst_req no_issue", n_pulse, 0);
    check_val("rst_req opA", md_operandA, 0);

    // Back-to-back instructions, req_valid held through each DONE
    run_op("mul_7x-6",    1'b0, 32'd7,          32'hFFFF_FFFA, 5'd5,  5'd5,  32'hFFFF_FFD6, 1'b0, 19);
    run_op("div_-100/7",  1'b1, 32'hFFFF_FF9C,  32'd7,         5'd9,  5'd9,  32'hFFFF_FFF2, 1'b0, 36);
    run_op("div_5/0",     1'b1, 32'd5,          32'd0,         5'd12, 5'd30, 32'd5,         1'b1, 36);
    run_op("mul_ovf",     1'b0, 32'h4000_0000,  32'd4,         5'd3,  5'd30, 32'd4,         1'b1, 19);
    run_op("mul_rd0",     1'b0, 32'd3,          32'd5,         5'd0,  5'd0,  32'd15,        1'b0, 19);
    @(negedge clock);
    req_valid = 1'b0;
    check_val("b2b wb_single", wb_valid, 0);
    n_pulse = 0;
    repeat (3) begin
      @(negedge clock);
      n_pulse += int'(md_ctrl_MULT) + int'(md_ctrl_DIV) + int'(stall);
    end
    check_val("idle no_issue", n_pulse, 0);

    // Unit never signals ready: 64 WAIT cycles then status write
    m_hold_low = 1'b1;
    run_op("mul_tmo", 1'b0, 32'd2, 32'd3, 5'd7, 5'd30, 32'd4, 1'b1, 66);
    run_op("div_tmo", 1'b1, 32'd8, 32'd2, 5'd8, 5'd30, 32'd5, 1'b1, 66);
    @(negedge clock);
    req_valid = 1'b0;
    m_hold_low = 1'b0;

    // Reset in the middle of WAIT drops the operation
    @(negedge clock);
    req_valid = 1'b1; req_is_div = 1'b0; req_a = 32'd9; req_b = 32'd9; req_rd = 5'd4;
    repeat (5) @(negedge clock);
    reset = 1'b1; req_valid = 1'b0;
    #1 check_val("midrst stall_in_rst", stall, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_val("midrst stall", stall, 0);
    check_val("midrst wb_valid", wb_valid, 0);
    check_val("midrst wb_data", wb_data, 0);
    check_val("midrst opA", md_operandA, 0);
    n_wb = 0;
    repeat (40) begin
      @(negedge clock);
      n_wb += int'(wb_valid) + int'(stall);
    end
    check_val("midrst no_wb", n_wb, 0);
    run_op("mul_after_rst", 1'b0, 32'd9, 32'd9, 5'd4, 5'd4, 32'd81, 1'b0, 19);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
